// File: rtl/window_sum_k_pkg.sv
// Shared width derivations and lane helpers for the KxK window-sum engine.
// Pure constant functions; no hardware, so no latency or flow-control behaviour.
package window_sum_k_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int tree_lvl(input int k);
        return clog2(k);
    endfunction

    function automatic int col_w(input int pix_w, input int k);
        return pix_w + clog2(k);
    endfunction

    function automatic int sum_w(input int pix_w, input int k);
        return pix_w + clog2(k * k);
    endfunction

    // Operand count entering reduction level lvl (level 0 = the raw K lanes).
    function automatic int lvl_cnt(input int k, input int lvl);
        return (k + (1 << lvl) - 1) >> lvl;
    endfunction

    function automatic int lane_lsb(input int pix_w, input int lane);
        return lane * pix_w;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_sum_k_col_adder_tree.sv
// Registered reduction of K pixel lanes to one column sum; latency clog2(K) cycles.
// Free-running, no backpressure: a valid tag rides alongside the data.
module col_adder_tree
    import window_sum_k_pkg::*;
#(
    parameter  int K     = 5,
    parameter  int PIX_W = 8,
    localparam int COL_W = col_w(PIX_W, K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld_i,
    input  logic [K*PIX_W-1:0] col_i,
    output logic               vld_o,
    output logic [COL_W-1:0]   sum_o
);

    localparam int LVL = tree_lvl(K);

    logic [COL_W-1:0] src    [LVL][K];
    logic [COL_W-1:0] node_q [LVL][K];
    logic [LVL-1:0]   vld_q;

    always_comb begin
        for (int l = 0; l < LVL; l++) begin
            for (int j = 0; j < K; j++) src[l][j] = '0;
        end
        for (int j = 0; j < K; j++) begin
            src[0][j] = COL_W'(col_i[lane_lsb(PIX_W, j) +: PIX_W]);
        end
        for (int l = 1; l < LVL; l++) begin
            for (int j = 0; j < K; j++) src[l][j] = node_q[l-1][j];
        end
    end

    // Pairs are summed; a trailing odd operand is carried to the next level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int l = 0; l < LVL; l++) begin
                for (int j = 0; j < K; j++) node_q[l][j] <= '0;
            end
        end else begin
            vld_q <= {vld_q[LVL-2:0], vld_i};
            for (int l = 0; l < LVL; l++) begin
                for (int j = 0; j < K; j++) node_q[l][j] <= '0;
                for (int j = 0; j < K / 2; j++) begin
                    if (2 * j + 1 < lvl_cnt(K, l)) begin
                        node_q[l][j] <= src[l][2*j] + src[l][2*j+1];
                    end
                end
                if (lvl_cnt(K, l) % 2 == 1) begin
                    node_q[l][lvl_cnt(K, l) / 2] <= src[l][lvl_cnt(K, l) - 1];
                end
            end
        end
    end

    assign vld_o = vld_q[LVL-1];
    assign sum_o = node_q[LVL-1][0];

endmodule

// File: rtl/window_sum_k.sv
// KxK sliding-window sum over streamed column vectors; beat to out_valid is clog2(K)+2 cycles.
// No backpressure: in_valid bubbles freeze window state, downstream must always accept.
module window_sum_k
    import window_sum_k_pkg::*;
#(
    parameter  int PIX_W = 8,
    parameter  int K     = 5,
    parameter  int COLS  = 640,
    parameter  int LINES = 480,
    localparam int SUM_W = sum_w(PIX_W, K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               sof_i,
    input  logic [K*PIX_W-1:0] col_i,
    output logic               out_valid,
    output logic [SUM_W-1:0]   sum_o,
    output logic [PIX_W-1:0]   center_o,
    output logic               line_last_o,
    output logic               frame_last_o
);

    localparam int R     = (K - 1) / 2;
    localparam int LVL   = tree_lvl(K);
    localparam int COL_W = col_w(PIX_W, K);
    localparam int CW    = cnt_w(COLS);
    localparam int LW    = cnt_w(LINES);

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_KM1   = CW'(K - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);

    typedef struct packed {
        logic [CW-1:0]    col;
        logic [LW-1:0]    line;
        logic [PIX_W-1:0] ctr;
    } meta_t;

    logic [CW-1:0] col_cnt_q, col_cnt_d, beat_col;
    logic [LW-1:0] line_cnt_q, line_cnt_d, beat_line;

    logic               s0_vld_q;
    logic [K*PIX_W-1:0] s0_col_q;
    meta_t              s0_meta_q;

    logic             t_vld;
    logic [COL_W-1:0] t_sum;
    meta_t            meta_q [LVL];
    meta_t            t_meta;

    logic [COL_W-1:0] hist_q     [K];
    logic [PIX_W-1:0] ctr_hist_q [R];
    logic [SUM_W-1:0] acc_q, acc_d;
    logic             win_full;

    logic             out_vld_q;
    logic [SUM_W-1:0] sum_q;
    logic [PIX_W-1:0] center_q;
    logic             line_last_q;
    logic             frame_last_q;

    // A start-of-frame beat takes position (0,0) itself, so counting resumes from there.
    always_comb begin
        beat_col   = sof_i ? '0 : col_cnt_q;
        beat_line  = sof_i ? '0 : line_cnt_q;
        col_cnt_d  = col_cnt_q;
        line_cnt_d = line_cnt_q;
        if (in_valid) begin
            if (beat_col == COL_LAST) begin
                col_cnt_d  = '0;
                line_cnt_d = (beat_line == LINE_LAST) ? '0 : beat_line + 1'b1;
            end else begin
                col_cnt_d  = beat_col + 1'b1;
                line_cnt_d = beat_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_q  <= '0;
            line_cnt_q <= '0;
            s0_vld_q   <= 1'b0;
            s0_col_q   <= '0;
            s0_meta_q  <= '0;
        end else begin
            col_cnt_q  <= col_cnt_d;
            line_cnt_q <= line_cnt_d;
            s0_vld_q   <= in_valid;
            if (in_valid) begin
                s0_col_q  <= col_i;
                s0_meta_q <= '{col: beat_col, line: beat_line,
                               ctr: col_i[lane_lsb(PIX_W, R) +: PIX_W]};
            end
        end
    end

    col_adder_tree #(
        .K     (K),
        .PIX_W (PIX_W)
    ) u_tree (
        .clk   (clk),
        .rst   (rst),
        .vld_i (s0_vld_q),
        .col_i (s0_col_q),
        .vld_o (t_vld),
        .sum_o (t_sum)
    );

    // Beat position and centre lane follow the tree so they line up with its output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LVL; i++) meta_q[i] <= '0;
        end else begin
            meta_q[0] <= s0_meta_q;
            for (int i = 1; i < LVL; i++) meta_q[i] <= meta_q[i-1];
        end
    end

    assign t_meta = meta_q[LVL-1];

    always_comb begin
        if (t_meta.col == '0) begin
            acc_d = SUM_W'(t_sum);
        end else if (t_meta.col <= COL_KM1) begin
            acc_d = acc_q + SUM_W'(t_sum);
        end else begin
            acc_d = acc_q + SUM_W'(t_sum) - SUM_W'(hist_q[K-1]);
        end
        win_full = t_vld && (t_meta.col >= COL_KM1);
    end

    // hist_q[K-1] is the column leaving the window; ctr_hist_q[R-1] is the window centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            out_vld_q    <= 1'b0;
            sum_q        <= '0;
            center_q     <= '0;
            line_last_q  <= 1'b0;
            frame_last_q <= 1'b0;
            for (int i = 0; i < K; i++) hist_q[i] <= '0;
            for (int i = 0; i < R; i++) ctr_hist_q[i] <= '0;
        end else begin
            out_vld_q    <= win_full;
            line_last_q  <= win_full && (t_meta.col == COL_LAST);
            frame_last_q <= win_full && (t_meta.col == COL_LAST) && (t_meta.line == LINE_LAST);
            if (t_vld) begin
                acc_q         <= acc_d;
                hist_q[0]     <= t_sum;
                ctr_hist_q[0] <= t_meta.ctr;
                for (int i = 1; i < K; i++) hist_q[i] <= hist_q[i-1];
                for (int i = 1; i < R; i++) ctr_hist_q[i] <= ctr_hist_q[i-1];
            end
            if (win_full) begin
                sum_q    <= acc_d;
                center_q <= ctr_hist_q[R-1];
            end
        end
    end

    assign out_valid    = out_vld_q;
    assign sum_o        = sum_q;
    assign center_o     = center_q;
    assign line_last_o  = line_last_q;
    assign frame_last_o = frame_last_q;

endmodule

// File: tb/tb_window_sum_k.sv
// Bench for window_sum_k (K=5, PIX_W=8, COLS=7, LINES=3): table scenarios, corner sequences,
// and random traffic checked against a line-buffer reference model.
module tb_window_sum_k;

    localparam int K     = 5;
    localparam int PIX_W = 8;
    localparam int COLS  = 7;
    localparam int LINES = 3;
    localparam int SUM_W = 13;
    localparam int LAT   = 5;
    localparam int R     = (K - 1) / 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               sof_i;
    logic [K*PIX_W-1:0] col_i;
    logic               out_valid;
    logic [SUM_W-1:0]   sum_o;
    logic [PIX_W-1:0]   center_o;
    logic               line_last_o;
    logic               frame_last_o;

    window_sum_k #(
        .PIX_W (PIX_W),
        .K     (K),
        .COLS  (COLS),
        .LINES (LINES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .sof_i        (sof_i),
        .col_i        (col_i),
        .out_valid    (out_valid),
        .sum_o        (sum_o),
        .center_o     (center_o),
        .line_last_o  (line_last_o),
        .frame_last_o (frame_last_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int sum;
        int ctr;
        bit ll;
        bit fl;
    } exp_t;

    typedef struct {
        int mode;
        bit bubble;
        int s [3];
        int c [3];
    } vec_t;

    exp_t exp_q [$];
    exp_t obs_q [$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    int   last_sum = 0;
    int   last_ctr = 0;

    int                 m_col = 0;
    int                 m_line = 0;
    logic [K*PIX_W-1:0] m_buf [COLS];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pix(input logic [K*PIX_W-1:0] v, input int k);
        logic [K*PIX_W-1:0] t;
        t = v >> (k * PIX_W);
        return int'(t[PIX_W-1:0]);
    endfunction

    function automatic logic [K*PIX_W-1:0] mkcol(input int p);
        logic [K*PIX_W-1:0] v;
        for (int k = 0; k < K; k++) v[k*PIX_W +: PIX_W] = PIX_W'(p);
        return v;
    endfunction

    function automatic logic [K*PIX_W-1:0] rndcol();
        logic [K*PIX_W-1:0] v;
        for (int k = 0; k < K; k++) v[k*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic logic [K*PIX_W-1:0] scn_col(input int mode, input int c);
        case (mode)
            0:       return mkcol(1);
            1:       return mkcol(255);
            default: return mkcol(c);
        endcase
    endfunction

    function automatic vec_t mk(input int mode, input bit bub, input int s0, input int s1,
                                input int s2, input int c0, input int c1, input int c2);
        vec_t t;
        t.mode = mode;  t.bubble = bub;
        t.s[0] = s0;    t.s[1] = s1;    t.s[2] = s2;
        t.c[0] = c0;    t.c[1] = c1;    t.c[2] = c2;
        return t;
    endfunction

    // Reference: keep every column of the current line and sum the last K of them directly.
    task automatic model_beat(input logic [K*PIX_W-1:0] v, input bit sof);
        exp_t e;
        int   s;
        if (sof) begin
            m_col  = 0;
            m_line = 0;
        end
        m_buf[m_col] = v;
        if (m_col >= K - 1) begin
            s = 0;
            for (int c = m_col - K + 1; c <= m_col; c++) begin
                for (int k = 0; k < K; k++) s += pix(m_buf[c], k);
            end
            e.cyc = cyc + LAT;
            e.sum = s;
            e.ctr = pix(m_buf[m_col - R], R);
            e.ll  = (m_col == COLS - 1);
            e.fl  = e.ll && (m_line == LINES - 1);
            exp_q.push_back(e);
        end
        m_col++;
        if (m_col == COLS) begin
            m_col  = 0;
            m_line = (m_line + 1) % LINES;
        end
    endtask

    task automatic beat(input logic [K*PIX_W-1:0] v, input bit sof);
        in_valid = 1'b1;
        sof_i    = sof;
        col_i    = v;
        model_beat(v, sof);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof_i    = 1'b0;
        col_i    = rndcol();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            sof_i    = ($urandom_range(0, 3) == 0);
            col_i    = rndcol();
            @(posedge clk);
            #1;
        end
        sof_i = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        sof_i    = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        m_col  = 0;
        m_line = 0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        last_sum = 0;
        last_ctr = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missing output: no out_valid by cycle %0d, expected sum %0d at cycle %0d",
                         cyc, exp_q[0].sum, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (out_valid) begin
                exp_t o;
                o.cyc = cyc;
                o.sum = int'(sum_o);
                o.ctr = int'(center_o);
                o.ll  = line_last_o;
                o.fl  = frame_last_o;
                obs_q.push_back(o);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected out_valid: got 1, expected 0 (sum %0d, cycle %0d)",
                             o.sum, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out cycle", cyc, e.cyc);
                    chk("sum_o", o.sum, e.sum);
                    chk("center_o", o.ctr, e.ctr);
                    chk("line_last_o", int'(o.ll), int'(e.ll));
                    chk("frame_last_o", int'(o.fl), int'(e.fl));
                    last_sum = e.sum;
                    last_ctr = e.ctr;
                end
            end else begin
                chk("hold sum_o", int'(sum_o), last_sum);
                chk("hold center_o", int'(center_o), last_ctr);
                chk("idle line_last_o", int'(line_last_o), 0);
                chk("idle frame_last_o", int'(frame_last_o), 0);
            end
        end
    end

    initial begin
        vec_t tbl [4];
        int   t5;
        int   r;

        tbl[0] = mk(0, 1'b0,   25,   25,   25,   1,   1,   1);
        tbl[1] = mk(1, 1'b0, 6375, 6375, 6375, 255, 255, 255);
        tbl[2] = mk(2, 1'b0,   50,   75,  100,   2,   3,   4);
        tbl[3] = mk(2, 1'b1,   50,   75,  100,   2,   3,   4);

        rst      = 1'b1;
        in_valid = 1'b0;
        sof_i    = 1'b0;
        col_i    = '0;
        do_reset();
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset sum_o", int'(sum_o), 0);
        chk("reset center_o", int'(center_o), 0);
        chk("reset line_last_o", int'(line_last_o), 0);
        chk("reset frame_last_o", int'(frame_last_o), 0);
        mon_en = 1'b1;

        for (int t = 0; t < 4; t++) begin
            obs_q.delete();
            for (int l = 0; l < LINES; l++) begin
                for (int c = 0; c < COLS; c++) begin
                    beat(scn_col(tbl[t].mode, c), (l == 0 && c == 0));
                    if (tbl[t].bubble) idle(1);
                end
            end
            idle(LAT + 3);
            chk($sformatf("scn%0d outputs", t), obs_q.size(), 9);
            for (int i = 0; i < obs_q.size() && i < 9; i++) begin
                chk($sformatf("scn%0d sum[%0d]", t, i), obs_q[i].sum, tbl[t].s[i%3]);
                chk($sformatf("scn%0d ctr[%0d]", t, i), obs_q[i].ctr, tbl[t].c[i%3]);
                chk($sformatf("scn%0d ll[%0d]", t, i), int'(obs_q[i].ll), int'(i % 3 == 2));
                chk($sformatf("scn%0d fl[%0d]", t, i), int'(obs_q[i].fl), int'(i == 8));
            end
        end

        // Line 0 ones, line 1 hundreds, line 2 ones: windows must not straddle lines.
        obs_q.delete();
        for (int l = 0; l < LINES; l++) begin
            for (int c = 0; c < COLS; c++) beat(mkcol(l == 1 ? 100 : 1), (l == 0 && c == 0));
        end
        idle(LAT + 3);
        chk("mix outputs", obs_q.size(), 9);
        if (obs_q.size() == 9) begin
            chk("mix line0 last", obs_q[2].sum, 25);
            chk("mix line1 first", obs_q[3].sum, 2500);
            chk("mix line1 last", obs_q[5].sum, 2500);
            chk("mix line2 first", obs_q[6].sum, 25);
        end

        // Reset after three beats; five fresh beats are then needed for the first window.
        obs_q.delete();
        for (int c = 0; c < 3; c++) beat(mkcol(c), (c == 0));
        do_reset();
        t5 = 0;
        for (int c = 0; c < COLS; c++) begin
            if (c == K - 1) t5 = cyc;
            beat(mkcol(c), 1'b0);
        end
        idle(LAT + 3);
        chk("abort outputs", obs_q.size(), 3);
        if (obs_q.size() > 0) begin
            chk("abort first latency", obs_q[0].cyc - t5, LAT);
            chk("abort first sum", obs_q[0].sum, 50);
            chk("abort first ctr", obs_q[0].ctr, 2);
        end

        // sof on the fourth beat of line 1 restarts at line 0.
        obs_q.delete();
        for (int c = 0; c < COLS; c++) beat(mkcol(c), (c == 0));
        for (int c = 0; c < 3; c++) beat(mkcol(c), 1'b0);
        for (int c = 0; c < COLS; c++) beat(mkcol(c), (c == 0));
        idle(LAT + 3);
        chk("sof outputs", obs_q.size(), 6);
        if (obs_q.size() == 6) begin
            for (int i = 3; i < 6; i++) begin
                chk($sformatf("sof sum[%0d]", i), obs_q[i].sum, 50 + 25 * (i - 3));
                chk($sformatf("sof ctr[%0d]", i), obs_q[i].ctr, i - 1);
                chk($sformatf("sof ll[%0d]", i), int'(obs_q[i].ll), int'(i == 5));
            end
            chk("sof fl", int'(obs_q[5].fl), 0);
        end

        // Random traffic: bubbles, occasional sof and reset.
        beat(rndcol(), 1'b1);
        for (int i = 0; i < 900; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1)       do_reset();
            else if (r < 3)  beat(rndcol(), 1'b1);
            else if (r < 75) beat(rndcol(), 1'b0);
            else             idle(1);
        end
        idle(LAT + 5);
        chk("queue drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
